// File: rtl/fse_pkg.sv
// Shared widths, types and arithmetic helpers for the fractionally-spaced
// equalizer LMS tap-update datapath.
package fse_pkg;

  localparam int NUM_TAPS = 11;
  localparam int NBT_IN   = 8;
  localparam int NBF_IN   = 7;
  localparam int NBT_ERR  = 12;
  localparam int NBF_ERR  = 9;
  localparam int NBT_TAPS = 28;
  localparam int NBF_TAPS = 25;

  // Gradient e*conj(x) keeps full precision: S(21,16).
  localparam int NBT_GRAD = NBT_IN + NBT_ERR + 1;
  localparam int NBF_GRAD = NBF_IN + NBF_ERR;
  localparam int GRAD_LSH = NBF_TAPS - NBF_GRAD;
  localparam int NBT_STEP = NBT_GRAD + GRAD_LSH;
  localparam int NBT_ACC  = NBT_TAPS + 3;

  localparam int CENTER_TAP = (NUM_TAPS - 1) / 2;

  typedef logic signed [NBT_IN-1:0]   sample_t;
  typedef logic signed [NBT_ERR-1:0]  err_t;
  typedef logic signed [NBT_TAPS-1:0] tap_t;
  typedef logic signed [NBT_GRAD-1:0] grad_t;
  typedef logic signed [NBT_STEP-1:0] step_t;
  typedef logic signed [NBT_ACC-1:0]  acc_t;

  localparam tap_t TAP_ONE = tap_t'(1 << NBF_TAPS);
  localparam tap_t TAP_MAX = tap_t'((1 << (NBT_TAPS-1)) - 1);
  localparam tap_t TAP_MIN = tap_t'(-(1 << (NBT_TAPS-1)));

  function automatic tap_t sat_tap(input acc_t v);
    if (v > acc_t'(TAP_MAX))      return TAP_MAX;
    else if (v < acc_t'(TAP_MIN)) return TAP_MIN;
    else                          return v[NBT_TAPS-1:0];
  endfunction

  // Arithmetic right shift: truncates toward minus infinity.
  function automatic step_t ashr_step(input step_t v, input logic [3:0] sh);
    return v >>> sh;
  endfunction

endpackage

// File: rtl/lms_tap_cell.sv
// One complex LMS tap: gradient register, mu scaling, saturating update and
// the tap register itself.
module lms_tap_cell
  import fse_pkg::*;
#(
  parameter tap_t RST_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       update,
  input  logic [3:0] mu_shift,
  input  sample_t    x_i,
  input  sample_t    x_q,
  input  err_t       e_i,
  input  err_t       e_q,
  output tap_t       w_i,
  output tap_t       w_q
);

  grad_t gi_c, gq_c;
  grad_t g_i_p1, g_q_p1;
  step_t step_i, step_q;
  acc_t  acc_i, acc_q;

  always_comb begin
    gi_c = grad_t'(e_i) * grad_t'(x_i) + grad_t'(e_q) * grad_t'(x_q);
    gq_c = grad_t'(e_q) * grad_t'(x_i) - grad_t'(e_i) * grad_t'(x_q);
  end

  // Stage 1: gradient e*conj(x)
  always_ff @(posedge clk) begin
    if (load) begin
      g_i_p1 <= gi_c;
      g_q_p1 <= gq_c;
    end
  end

  always_comb begin
    step_i = ashr_step(step_t'(g_i_p1) <<< GRAD_LSH, mu_shift);
    step_q = ashr_step(step_t'(g_q_p1) <<< GRAD_LSH, mu_shift);
    acc_i  = acc_t'(w_i) - acc_t'(step_i);
    acc_q  = acc_t'(w_q) - acc_t'(step_q);
  end

  // Stage 2: saturating tap update
  always_ff @(posedge clk) begin
    if (reset) begin
      w_i <= RST_VAL;
      w_q <= '0;
    end else if (update) begin
      w_i <= sat_tap(acc_i);
      w_q <= sat_tap(acc_q);
    end
  end

endmodule

// File: rtl/fse_lms_update.sv
// LMS coefficient update for the T/2 fractionally-spaced equalizer: sample
// delay line, symbol-rate strobe generation and per-tap update cells.
module fse_lms_update
  import fse_pkg::*;
(
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_en,
  input  logic [NBT_IN-1:0]            i_is_data_I,
  input  logic [NBT_IN-1:0]            i_is_data_Q,
  input  logic [NBT_ERR-1:0]           i_err_I,
  input  logic [NBT_ERR-1:0]           i_err_Q,
  input  logic [3:0]                   i_mu_shift,
  input  logic                         i_adapt,
  output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_I,
  output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_Q,
  output logic                         o_upd_valid
);

  sample_t dl_i [NUM_TAPS];
  sample_t dl_q [NUM_TAPS];
  sample_t nx_i [NUM_TAPS];
  sample_t nx_q [NUM_TAPS];
  logic    phase;
  logic    strobe;
  logic    vld_p1;
  logic    vld_p2;

  assign strobe = i_en & phase;

  // The gradient sees the line as it stands after this cycle's shift.
  always_comb begin
    nx_i[0] = sample_t'(i_is_data_I);
    nx_q[0] = sample_t'(i_is_data_Q);
    for (int k = 1; k < NUM_TAPS; k++) begin
      nx_i[k] = dl_i[k-1];
      nx_q[k] = dl_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      dl_i   <= '{default: '0};
      dl_q   <= '{default: '0};
      phase  <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (i_en) begin
        dl_i  <= nx_i;
        dl_q  <= nx_q;
        phase <= ~phase;
      end
      vld_p1 <= strobe & i_adapt;
      vld_p2 <= vld_p1;
    end
  end

  assign o_upd_valid = vld_p2;

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    tap_t w_i, w_q;

    lms_tap_cell #(
      .RST_VAL((k == CENTER_TAP) ? TAP_ONE : tap_t'(0))
    ) u_cell (
      .clk      (clk),
      .reset    (i_reset),
      .load     (strobe & i_adapt),
      .update   (vld_p1),
      .mu_shift (i_mu_shift),
      .x_i      (nx_i[k]),
      .x_q      (nx_q[k]),
      .e_i      (err_t'(i_err_I)),
      .e_q      (err_t'(i_err_Q)),
      .w_i      (w_i),
      .w_q      (w_q)
    );

    assign o_taps_I[k*NBT_TAPS +: NBT_TAPS] = w_i;
    assign o_taps_Q[k*NBT_TAPS +: NBT_TAPS] = w_q;
  end

endmodule

// File: tb/tb_fse_lms_update.sv
// Directed bench for fse_lms_update with hand-computed tap values.
module tb_fse_lms_update;

  localparam int NT = 11;
  localparam int TW = 28;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [7:0]     xi = '0, xq = '0;
  logic [11:0]    ei = '0, eq = '0;
  logic [3:0]     mu = '0;
  logic           adapt = 1'b0;
  logic [NT*TW-1:0] taps_i, taps_q;
  logic           upd;

  int errors = 0;
  int checks = 0;

  fse_lms_update dut (
    .clk         (clk),
    .i_reset     (rst),
    .i_en        (en),
    .i_is_data_I (xi),
    .i_is_data_Q (xq),
    .i_err_I     (ei),
    .i_err_Q     (eq),
    .i_mu_shift  (mu),
    .i_adapt     (adapt),
    .o_taps_I    (taps_i),
    .o_taps_Q    (taps_q),
    .o_upd_valid (upd)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] tap_of(input logic [NT*TW-1:0] bus, input int k);
    return bus[k*TW +: TW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_taps(input string tag);
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("%s_tapI%0d", tag, k), 64'(tap_of(taps_i, k)),
          (k == 5) ? 64'h2000000 : 64'h0);
      chk($sformatf("%s_tapQ%0d", tag, k), 64'(tap_of(taps_q, k)), 64'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_in(input logic [7:0] a, input logic [7:0] b,
                        input logic [11:0] c, input logic [11:0] d);
    xi = a; xq = b; ei = c; eq = d;
  endtask

  // Two i_en pulses (second is the strobe), then one more clock for stage 2.
  task automatic pair_update(input logic [3:0] m);
    mu = m;
    adapt = 1'b1;
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    chk("stage1_no_upd", 64'(upd), 64'h0);
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_reset_taps("rst");
    chk("rst_upd", 64'(upd), 64'h0);
    rst = 1'b0;
    tick();

    // Single update, mu_shift = 0
    set_in(8'd64, 8'd0, 12'd256, 12'd0);
    pair_update(4'd0);
    chk("single_upd", 64'(upd), 64'h1);
    chk("single_tap0I", 64'(tap_of(taps_i, 0)), 64'hF800000);
    chk("single_tap1I", 64'(tap_of(taps_i, 1)), 64'hF800000);
    chk("single_tap0Q", 64'(tap_of(taps_q, 0)), 64'h0);
    chk("single_tap5I", 64'(tap_of(taps_i, 5)), 64'h2000000);
    tick();
    chk("single_upd_once", 64'(upd), 64'h0);

    // Single update, mu_shift = 4
    do_reset();
    rst = 1'b0;
    set_in(8'd64, 8'd0, 12'd256, 12'd0);
    pair_update(4'd4);
    chk("mu4_upd", 64'(upd), 64'h1);
    chk("mu4_tap0I", 64'(tap_of(taps_i, 0)), 64'hFF80000);

    // Conjugate: x = j*0.5, e = 0.5
    do_reset();
    rst = 1'b0;
    set_in(8'd0, 8'd64, 12'd256, 12'd0);
    pair_update(4'd0);
    chk("conj_tap0I", 64'(tap_of(taps_i, 0)), 64'h0);
    chk("conj_tap0Q", 64'(tap_of(taps_q, 0)), 64'h800000);

    // Freeze then adapt with i_en every other clock
    do_reset();
    rst = 1'b0;
    set_in(8'd64, 8'd0, 12'd256, 12'd0);
    mu = 4'd0;
    adapt = 1'b0;
    for (int c = 0; c < 20; c++) begin
      en = (c < 16) && (c % 2 == 0);
      tick();
      chk($sformatf("frz_upd_c%0d", c), 64'(upd), 64'h0);
    end
    chk_reset_taps("frz");
    adapt = 1'b1;
    for (int c = 0; c < 20; c++) begin
      en = (c < 16) && (c % 2 == 0);
      tick();
      chk($sformatf("adp_upd_c%0d", c), 64'(upd),
          (c == 3 || c == 7 || c == 11 || c == 15) ? 64'h1 : 64'h0);
    end
    en = 1'b0;

    // Saturation at +max
    do_reset();
    rst = 1'b0;
    set_in(8'd127, 8'd0, 12'h800, 12'd0);
    mu = 4'd0;
    adapt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      en = 1'b1;
      tick();
      if (c == 2) chk("sat_first", 64'(tap_of(taps_i, 0)), 64'h7F00000);
      if (c == 4 || c == 8)
        chk($sformatf("sat_clamp_c%0d", c), 64'(tap_of(taps_i, 0)), 64'h7FFFFFF);
    end
    en = 1'b0;
    tick();
    tick();
    chk("sat_final_I", 64'(tap_of(taps_i, 0)), 64'h7FFFFFF);
    chk("sat_final_Q", 64'(tap_of(taps_q, 0)), 64'h0);

    // Reset in the clock after a strobe
    do_reset();
    rst = 1'b0;
    set_in(8'd64, 8'd0, 12'd256, 12'd0);
    adapt = 1'b1;
    en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    en = 1'b0;
    tick();
    chk("mid_rst_upd", 64'(upd), 64'h0);
    chk("mid_rst_tap0I", 64'(tap_of(taps_i, 0)), 64'h0);
    chk("mid_rst_tap5I", 64'(tap_of(taps_i, 5)), 64'h2000000);
    rst = 1'b0;
    en = 1'b1;
    tick();
    chk("rel_first_en_upd", 64'(upd), 64'h0);
    chk("rel_first_en_tap0I", 64'(tap_of(taps_i, 0)), 64'h0);
    tick();
    chk("rel_strobe_upd", 64'(upd), 64'h0);
    en = 1'b0;
    tick();
    chk("rel_upd", 64'(upd), 64'h1);
    chk("rel_tap0I", 64'(tap_of(taps_i, 0)), 64'hF800000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
